// File: rtl/slug_link_pkg.sv
// ============================================================================
// Module   : slug_link_pkg
// Purpose  : Shared bit positions and FSM state types for the slug_link bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package slug_link_pkg;

  // Bit positions inside the 32-bit CPU ports
  localparam int H2C_TGL = 8;   // port_in  : host-to-CPU toggle
  localparam int C2H_ACK = 12;  // port_in  : CPU-to-host ack toggle
  localparam int C2H_TGL = 8;   // port_out : CPU-to-host toggle
  localparam int H2C_ACK = 12;  // port_out : host-to-CPU ack toggle

  localparam int WAIT_CNT_W = 16;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } tx_state_t;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_FULL = 1'b1
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/slug_link.sv
// ============================================================================
// Module   : slug_link
// Purpose  : Toggle-handshake byte bridge between a host stream interface and
//            a CPU's 32-bit input/output ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slug_link
  import slug_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        tx_timeout,
  output logic [31:0] port_in,
  input  logic [31:0] port_out
);

  localparam logic [WAIT_CNT_W-1:0] c_timeout_cnt = WAIT_CNT_W'(TIMEOUT_CYCLES);

  logic [31:0]           r_po_q;
  tx_state_t             r_tx_state;
  tx_state_t             w_tx_state_nxt;
  rx_state_t             r_rx_state;
  rx_state_t             w_rx_state_nxt;
  logic [7:0]            r_h2c_byte;
  logic                  r_h2c_tgl;
  logic                  r_c2h_ack;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] w_wait_inc;
  logic                  r_tx_timeout;
  logic [7:0]            r_rx_data;
  logic                  w_tx_accept;
  logic                  w_rx_capture;
  logic                  w_rx_consume;
  logic                  w_unused_po;

  // The CPU port is asynchronous to our view of it; every decision uses the registered copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_po_q <= '0;
    end else begin
      r_po_q <= port_out;
    end
  end

  assign w_unused_po = ^{r_po_q[31:13], r_po_q[11:9]};

  // ---------------------------------------------------------------- TX FSM
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_accept    = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (tx_valid) begin
          w_tx_accept    = 1'b1;
          w_tx_state_nxt = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (r_po_q[H2C_ACK] == r_h2c_tgl) begin
          w_tx_state_nxt = TX_IDLE;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  assign w_wait_inc = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 1'b1;

  // Timeout is only a status flag; the handshake keeps waiting for the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state   <= TX_IDLE;
      r_h2c_byte   <= '0;
      r_h2c_tgl    <= 1'b0;
      r_wait_cnt   <= '0;
      r_tx_timeout <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (w_tx_accept) begin
        r_h2c_byte <= tx_data;
        r_h2c_tgl  <= ~r_h2c_tgl;
        r_wait_cnt <= '0;
      end else if (r_tx_state == TX_WAIT) begin
        r_wait_cnt <= w_wait_inc;
        if (w_wait_inc >= c_timeout_cnt) begin
          r_tx_timeout <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- RX FSM
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_capture   = 1'b0;
    w_rx_consume   = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_po_q[C2H_TGL] != r_c2h_ack) begin
          w_rx_capture   = 1'b1;
          w_rx_state_nxt = RX_FULL;
        end
      end
      RX_FULL: begin
        if (rx_ready) begin
          w_rx_consume   = 1'b1;
          w_rx_state_nxt = RX_IDLE;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_data  <= '0;
      r_c2h_ack  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      if (w_rx_capture) begin
        r_rx_data <= r_po_q[7:0];
      end
      if (w_rx_consume) begin
        r_c2h_ack <= ~r_c2h_ack;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    port_in          = '0;
    port_in[7:0]     = r_h2c_byte;
    port_in[H2C_TGL] = r_h2c_tgl;
    port_in[C2H_ACK] = r_c2h_ack;
  end

  assign tx_ready   = (r_tx_state == TX_IDLE) && !rst;
  assign rx_valid   = (r_rx_state == RX_FULL);
  assign rx_data    = r_rx_data;
  assign tx_timeout = r_tx_timeout;

endmodule

`default_nettype wire

// File: tb/tb_slug_link.sv
// ============================================================================
// Module   : tb_slug_link
// Purpose  : Self-checking bench for slug_link with a behavioural CPU model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slug_link;

  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b0;
  logic        tx_timeout;
  logic [31:0] port_in;
  logic [31:0] port_out;

  // CPU-side port fields
  logic [7:0]  cpu_c2h_byte = 8'h00;
  logic        cpu_c2h_tgl  = 1'b0;
  logic        cpu_h2c_ack  = 1'b0;

  assign port_out = {19'd0, cpu_h2c_ack, 3'd0, cpu_c2h_tgl, cpu_c2h_byte};

  always #5 clk = ~clk;

  slug_link #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .tx_timeout(tx_timeout),
    .port_in   (port_in),
    .port_out  (port_out)
  );

  int tests = 0;
  int fails = 0;

  bit         cpu_auto_ack  = 1'b1;
  int         cpu_ack_delay = 1;
  bit         cpu_seen      = 1'b0;
  int         cpu_cnt       = 0;
  logic [7:0] cpu_log[$];
  logic       cpu_tgl_log[$];
  logic [7:0] sent_q[$];
  logic       exp_tgl = 1'b0;
  logic       exp_ack = 1'b0;

  // CPU model: logs each new host byte, acks cpu_ack_delay cycles later.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        cpu_h2c_ack = 1'b0;
        cpu_seen    = 1'b0;
        cpu_cnt     = 0;
      end else if (port_in[8] != cpu_h2c_ack) begin
        if (!cpu_seen) begin
          cpu_seen = 1'b1;
          cpu_cnt  = 0;
          cpu_log.push_back(port_in[7:0]);
          cpu_tgl_log.push_back(port_in[8]);
        end else begin
          cpu_cnt++;
          if (cpu_auto_ack && cpu_cnt >= cpu_ack_delay) begin
            cpu_h2c_ack = port_in[8];
            cpu_seen    = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_ready();
    int n = 0;
    while (!tx_ready && n < 200) begin
      tick();
      n++;
    end
    chk("tx_ready_bound", tx_ready, 1);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    tx_valid     = 1'b0;
    rx_ready     = 1'b0;
    cpu_c2h_byte = 8'h00;
    cpu_c2h_tgl  = 1'b0;
    exp_tgl      = 1'b0;
    exp_ack      = 1'b0;
    tick();
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_port_in", port_in, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_timeout", tx_timeout, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_tx_ready", tx_ready, 1);
  endtask

  // Accept one byte, then measure the turnaround back to tx_ready.
  task automatic send_byte(input logic [7:0] b, input int d);
    int n;
    bit stable;
    cpu_ack_delay = d;
    wait_tx_ready();
    tx_valid = 1'b1;
    tx_data  = b;
    exp_tgl  = ~exp_tgl;
    sent_q.push_back(b);
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    chk("tx_byte", port_in[7:0], b);
    chk("tx_tgl", port_in[8], exp_tgl);
    chk("tx_busy", tx_ready, 0);
    n = 0;
    stable = 1'b1;
    while (!tx_ready && n < 100) begin
      tick();
      n++;
      if (port_in[8:0] !== {exp_tgl, b}) stable = 1'b0;
    end
    chk("tx_stable", stable, 1);
    chk("tx_turnaround", n, d + 2);
  endtask

  task automatic cpu_send(input logic [7:0] b);
    cpu_c2h_byte = b;
    cpu_c2h_tgl  = ~cpu_c2h_tgl;
  endtask

  // CPU sends a byte; host holds it for 'hold' cycles then consumes.
  task automatic rx_xfer(input logic [7:0] b, input int hold, input bit change_mid);
    bit stable = 1'b1;
    cpu_send(b);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rx_early", rx_valid, 0);
    chk("rx_idle_ready_ignored", port_in[12], exp_ack);
    tick();
    chk("rx_valid", rx_valid, 1);
    chk("rx_data", rx_data, b);
    for (int i = 0; i < hold; i++) begin
      if (change_mid && i == hold / 2) cpu_c2h_byte = 8'h77;
      tick();
      if (!(rx_valid === 1'b1 && rx_data === b && port_in[12] === exp_ack)) stable = 1'b0;
    end
    chk("rx_hold", stable, 1);
    rx_ready = 1'b1;
    exp_ack  = ~exp_ack;
    tick();
    rx_ready = 1'b0;
    chk("rx_ack", port_in[12], exp_ack);
    chk("rx_drained", rx_valid, 0);
    tick();
    chk("rx_no_recapture", rx_valid, 0);
  endtask

  initial begin
    int base;
    int logsz;
    logic [7:0] b;

    do_reset();

    send_byte(8'hA5, 2);
    rx_xfer(8'h3C, 10, 1'b1);

    // Back-to-back from a fresh reset
    do_reset();
    base = cpu_log.size();
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h03, 1);
    chk("b2b_count", cpu_log.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      if (base + k < cpu_log.size()) begin
        chk("b2b_byte", cpu_log[base + k], k + 1);
        chk("b2b_tgl", cpu_tgl_log[base + k], (k % 2 == 0) ? 1 : 0);
      end
    end

    // Simultaneous tx accept and rx consume
    cpu_send(8'h5A);
    tick();
    tick();
    chk("sim_rx_valid", rx_valid, 1);
    cpu_ack_delay = 1;
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    rx_ready = 1'b1;
    exp_tgl  = ~exp_tgl;
    exp_ack  = ~exp_ack;
    sent_q.push_back(8'hC3);
    tick();
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    chk("sim_tx_byte", port_in[7:0], 8'hC3);
    chk("sim_tx_tgl", port_in[8], exp_tgl);
    chk("sim_rx_ack", port_in[12], exp_ack);
    chk("sim_rx_drained", rx_valid, 0);
    chk("sim_rx_data_hold", rx_data, 8'h5A);
    wait_tx_ready();

    // Randomized traffic
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send_byte(b, int'($urandom_range(1, 8)));
      b = 8'($urandom);
      rx_xfer(b, int'($urandom_range(0, 4)), 1'b0);
    end

    // Timeout with the CPU silent
    cpu_auto_ack = 1'b0;
    wait_tx_ready();
    tx_valid = 1'b1;
    tx_data  = 8'h9E;
    exp_tgl  = ~exp_tgl;
    sent_q.push_back(8'h9E);
    tick();
    tx_valid = 1'b0;
    repeat (TIMEOUT - 1) tick();
    chk("to_not_yet", tx_timeout, 0);
    tick();
    chk("to_set", tx_timeout, 1);
    chk("to_still_wait", tx_ready, 0);
    repeat (5) tick();
    chk("to_keeps_wait", tx_ready, 0);
    chk("to_port_stable", port_in[8:0], {exp_tgl, 8'h9E});
    cpu_auto_ack = 1'b1;
    wait_tx_ready();
    chk("to_sticky", tx_timeout, 1);

    // Reset while TX waits and RX is full
    cpu_auto_ack = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h6B;
    exp_tgl  = ~exp_tgl;
    sent_q.push_back(8'h6B);
    cpu_send(8'hD4);
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_tx_wait", tx_ready, 0);
    chk("pre_rst_rx_full", rx_valid, 1);
    logsz = cpu_log.size();
    do_reset();
    cpu_auto_ack = 1'b1;
    repeat (4) tick();
    chk("no_replay_rx", rx_valid, 0);
    chk("no_replay_tx_ready", tx_ready, 1);
    chk("no_replay_port_in", port_in, 0);
    chk("no_replay_log", cpu_log.size(), logsz);
    send_byte(8'h42, 1);

    // End-to-end scoreboard
    chk("sb_count", cpu_log.size(), sent_q.size());
    foreach (sent_q[i]) begin
      if (i < cpu_log.size()) chk("sb_byte", cpu_log[i], sent_q[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
